// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and defaults for the FIFO read streamer.
package fifo_rd_stream_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_BUF_DEPTH  = 2;
    // Occupancy width covers every legal depth (2 or 4).
    localparam int OCC_W          = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Circular output skid buffer: head/tail pointers plus occupancy.
module rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = DEF_FIFO_WIDTH,
    parameter int DEPTH = DEF_BUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [WIDTH-1:0] head_data
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Streams FIFO read data to a valid/ready sink with flush and statistics.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    input  logic                  clr_stats,
    output logic [15:0]           word_cnt,
    output logic                  underflow_err
);

    state_t           state;
    logic             infl;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   level;
    logic             pop;
    logic             capture;
    logic             flush_go;
    logic             active;

    assign active   = (state == ACTIVE);
    assign m_valid  = (occ != '0);
    assign pop      = m_valid && m_ready;
    assign flush_go = flush && active;
    // A word landing during a flush (or outside ACTIVE) is dropped.
    assign capture  = infl && active && !flush;

    assign level = {1'b0, occ} + (OCC_W+1)'(infl) - (OCC_W+1)'(pop);

    assign fifo_rd_en = !fifo_empty && active && !flush
                        && (level < (OCC_W+1)'(BUF_DEPTH));

    rd_skid_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush_go),
        .push      (capture),
        .push_data (fifo_data_out),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            infl  <= 1'b0;
        end else begin
            infl <= fifo_rd_en;
            unique case (state)
                IDLE:    state <= ACTIVE;
                ACTIVE:  if (flush) state <= FLUSH;
                FLUSH:   if (!infl) state <= ACTIVE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt      <= '0;
            underflow_err <= 1'b0;
        end else if (clr_stats) begin
            word_cnt      <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (pop) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (fifo_underflow) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO source.
module tb_fifo_rd_stream;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] fifo_data_out;
    logic         fifo_empty;
    logic         fifo_underflow;
    logic         fifo_rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready;
    logic         flush;
    logic         clr_stats;
    logic [15:0]  word_cnt;
    logic         underflow_err;

    logic [W-1:0] mem [4096];
    logic [31:0]  rd_ptr = '0;
    logic [31:0]  wr_ptr;
    logic         src_inf;
    logic [W-1:0] inf_val = 16'h8000;

    int total = 0;
    int bad   = 0;
    int n;
    int g;
    int rd;
    int got;
    logic [31:0]  exp_idx;
    logic         hold;
    logic [W-1:0] prev_data;

    fifo_rd_stream #(
        .FIFO_WIDTH (W),
        .BUF_DEPTH  (D)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .flush          (flush),
        .clr_stats      (clr_stats),
        .word_cnt       (word_cnt),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = src_inf ? 1'b0 : (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (src_inf) begin
                fifo_data_out <= inf_val;
                inf_val       <= inf_val + 16'd1;
            end else begin
                fifo_data_out <= mem[rd_ptr[11:0]];
                rd_ptr        <= rd_ptr + 32'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] v);
        mem[wr_ptr[11:0]] = v;
        wr_ptr = wr_ptr + 32'd1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!m_valid && k < 50) begin
            tick();
            k++;
        end
        chk(tag, 32'(m_valid), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        m_ready        = 1'b1;
        flush          = 1'b0;
        clr_stats      = 1'b0;
        fifo_underflow = 1'b0;
        src_inf        = 1'b0;
        wr_ptr         = '0;
        for (int i = 1; i <= 8; i++) push(16'(i));

        // reset state
        #3;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        chk("rst_err", 32'(underflow_err), 32'd0);

        // streaming after reset release
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!fifo_rd_en && n < 10) begin
            tick();
            n++;
        end
        chk("first_rd_en", 32'(fifo_rd_en), 32'd1);
        tick();
        tick();
        for (int i = 1; i <= 8; i++) begin
            chk("stream_valid", 32'(m_valid), 32'd1);
            chk("stream_data", 32'(m_data), 32'(i));
            tick();
        end
        chk("stream_end_valid", 32'(m_valid), 32'd0);
        chk("stream_cnt", 32'(word_cnt), 32'd8);

        // backpressure
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(16'(i));
        #1;
        rd = 0;
        for (int c = 0; c < 10; c++) begin
            if (fifo_rd_en) rd++;
            tick();
        end
        chk("bp_reads", 32'(rd), 32'(D));
        chk("bp_rd_en_low", 32'(fifo_rd_en), 32'd0);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_hold", 32'(m_data), 32'h0001);
        m_ready = 1'b1;
        #1;
        for (int i = 1; i <= 8; i++) begin
            chk("bp_rel_valid", 32'(m_valid), 32'd1);
            chk("bp_rel_data", 32'(m_data), 32'(i));
            tick();
        end
        chk("bp_cnt", 32'(word_cnt), 32'd16);

        // flush with occ=2, one word in flight
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(16'(16'h21 + i));
        #1;
        chk("fl_rd0", 32'(fifo_rd_en), 32'd1);
        tick();
        tick();
        tick();
        chk("fl_pre_data", 32'(m_data), 32'h21);
        flush = 1'b1;
        #1;
        chk("fl_rd_gate", 32'(fifo_rd_en), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid_drop", 32'(m_valid), 32'd0);
        chk("fl_rd_in_flush", 32'(fifo_rd_en), 32'd0);
        m_ready = 1'b1;
        wait_valid("fl_resume");
        chk("fl_next0", 32'(m_data), 32'h24);
        tick();
        chk("fl_next1", 32'(m_data), 32'h25);
        tick();
        chk("fl_next2", 32'(m_data), 32'h26);
        tick();
        chk("fl_empty", 32'(m_valid), 32'd0);
        chk("fl_cnt", 32'(word_cnt), 32'd19);

        // random drain against scoreboard
        exp_idx = wr_ptr;
        for (int i = 0; i < 1000; i++) push(16'(i * 40503 + 3));
        got  = 0;
        g    = 0;
        hold = 1'b0;
        prev_data = '0;
        while (got < 1000 && g < 6000) begin
            m_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
            if (hold) chk("rnd_hold", 32'(m_data), 32'(prev_data));
            if (m_valid && m_ready) begin
                chk("rnd_sb", 32'(m_data), 32'(mem[exp_idx[11:0]]));
                exp_idx = exp_idx + 32'd1;
                got++;
            end
            hold      = m_valid && !m_ready;
            prev_data = m_data;
            tick();
            g++;
        end
        m_ready = 1'b0;
        chk("rnd_got", 32'(got), 32'd1000);
        chk("rnd_err", 32'(underflow_err), 32'd0);
        chk("rnd_cnt", 32'(word_cnt), 32'd1019);

        // underflow sticky, then clear with a coincident pop
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        chk("uf_set", 32'(underflow_err), 32'd1);
        tick();
        tick();
        chk("uf_sticky", 32'(underflow_err), 32'd1);
        push(16'h0042);
        m_ready = 1'b1;
        wait_valid("clr_wait");
        chk("clr_data", 32'(m_data), 32'h42);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_cnt", 32'(word_cnt), 32'd0);
        chk("clr_err", 32'(underflow_err), 32'd0);
        chk("clr_popped", 32'(m_valid), 32'd0);

        // counter wrap
        src_inf = 1'b1;
        n = 0;
        g = 0;
        while (n < 65537 && g < 70000) begin
            tick();
            if (m_valid) n++;
            g++;
        end
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        chk("wrap_pops", 32'(n), 32'd65537);
        chk("wrap_cnt", 32'(word_cnt), 32'd1);

        // asynchronous reset mid-stream
        fifo_underflow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            fifo_underflow = 1'b0;
        end
        chk("mr_pre_valid", 32'(m_valid), 32'd1);
        chk("mr_pre_err", 32'(underflow_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("mr_valid", 32'(m_valid), 32'd0);
        chk("mr_data", 32'(m_data), 32'd0);
        chk("mr_cnt", 32'(word_cnt), 32'd0);
        chk("mr_err", 32'(underflow_err), 32'd0);
        src_inf = 1'b0;
        tick();
        rst_n = 1'b1;
        push(16'h0051);
        push(16'h0052);
        m_ready = 1'b1;
        wait_valid("mr_wait");
        chk("mr_first", 32'(m_data), 32'h51);
        tick();
        chk("mr_second", 32'(m_data), 32'h52);
        tick();
        chk("mr_done", 32'(m_valid), 32'd0);
        chk("mr_cnt2", 32'(word_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, meaning the data word width, equal to the FIFO's width.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the number of output skid-buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_data_out  input  FIFO_WIDTH  FIFO read data; valid one cycle after fifo_rd_en is sampled high.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_underflow  input  1  FIFO underflow indication.
REQ-008 fifo_rd_en  output  1  FIFO read request.
REQ-009 m_valid  output  1  downstream word valid.
REQ-010 m_data  output  FIFO_WIDTH  downstream word.
REQ-011 m_ready  input  1  downstream accept.
REQ-012 flush  input  1  one-cycle pulse that discards all buffered and in-flight words.
REQ-013 clr_stats  input  1  synchronous clear of word_cnt and underflow_err.
REQ-014 word_cnt  output  16  count of words accepted downstream; wraps from 0xFFFF to 0.
REQ-015 underflow_err  output  1  sticky error flag.

Function
REQ-016 SHALL keep occupancy count occ (0..BUF_DEPTH) and in-flight flag infl (a read was issued last cycle).
REQ-017 SHALL drive fifo_rd_en = !fifo_empty && state==ACTIVE && !flush && (occ + infl - pop) < BUF_DEPTH, where pop = m_valid && m_ready.
REQ-018 SHALL capture fifo_data_out into the buffer tail on the cycle after fifo_rd_en was high, unless that word is discarded by flush.
REQ-019 SHALL present words in FIFO order; m_valid = (occ != 0); m_data = buffer head.
REQ-020 Once m_valid is high, m_data SHALL hold stable until it is accepted or flushed.
REQ-021 SHALL sustain one word per cycle when the FIFO is non-empty and m_ready is held high.
REQ-022 A simultaneous capture and pop SHALL leave occ unchanged.
REQ-023 A pop with occ==0 SHALL be impossible; a capture with occ==BUF_DEPTH SHALL be prevented by REQ-017.
REQ-024 FSM states SHALL be IDLE, ACTIVE and FLUSH.
REQ-025 IDLE SHALL go to ACTIVE on the cycle after reset release.
REQ-026 ACTIVE SHALL go to FLUSH when flush is high.
REQ-027 On entering FLUSH, SHALL set occ to 0 and drop m_valid that same edge.
REQ-028 FLUSH SHALL discard a landing in-flight word and return to ACTIVE when infl==0.
REQ-029 flush received while in FLUSH SHALL be ignored.
REQ-030 Every pop SHALL increment word_cnt.
REQ-031 clr_stats SHALL take priority over an increment in the same cycle.
REQ-032 fifo_underflow high in any cycle SHALL set underflow_err, which holds until clr_stats or reset.
REQ-033 fifo_rd_en SHALL never be high while fifo_empty is high.

Reset
REQ-034 While rst_n is low, all outputs SHALL be forced immediately: fifo_rd_en=0, m_valid=0, m_data=0, word_cnt=0, underflow_err=0.
REQ-035 While rst_n is low, internal state SHALL be state=IDLE, occ=0, infl=0.
REQ-036 Reset asserted mid-stream SHALL discard all buffered and in-flight words; the first word delivered after reset is the first word read after reset.

Structure
REQ-037 A shared package SHALL hold the FSM state enum and the default FIFO_WIDTH and BUF_DEPTH constants.
REQ-038 The skid buffer (circular storage, head/tail pointers, occ) SHALL be one sub-module, rd_skid_buf; the top holds the FSM, read control and statistics.

Verification
REQ-039 Reset case: FIFO preloaded with 0x0001..0x0008, m_ready=1 -> m_data 0x0001..0x0008 on 8 consecutive cycles, starting 2 cycles after the first fifo_rd_en; word_cnt=8.
REQ-040 Backpressure case: m_ready=0 for 10 cycles with the FIFO non-empty -> exactly BUF_DEPTH reads, then fifo_rd_en=0; m_data holds 0x0001; on release, order is preserved with no loss.
REQ-041 Flush case: pulse flush with occ=2 and infl=1 -> m_valid=0 the next cycle, the in-flight word is not output, state returns to ACTIVE, and the next word out is the FIFO's next entry.
REQ-042 Random-drain case: randomize m_ready 50% over 1000 words -> scoreboard matches, fifo_rd_en is never high with fifo_empty high, and underflow_err=0.
REQ-043 Error and stats case: force fifo_underflow=1 for 1 cycle -> underflow_err=1 and sticky; clr_stats with a coincident pop -> word_cnt=0 and underflow_err=0.
REQ-044 Wrap and mid-reset case: 65537 pops -> word_cnt=1; rst_n low mid-stream -> all outputs are 0 asynchronously.
